// File: rtl/tdm_pkg.sv
// tdm_pkg: definitions shared by the TDM demux and the transmit mux chain.
package tdm_pkg;
    typedef enum logic [0:0] {IDLE, COLLECT} state_e;
    localparam int FS_SLOT = 0;
    function automatic int slot_w(input int ch);
        return $clog2(ch);
    endfunction
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot index counter with clear, load-to-1, and increment that wraps at CH-1.
module tdm_slot_counter #(
    parameter int CH     = 4,
    parameter int SLOT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load1,
    input  logic              inc,
    output logic [SLOT_W-1:0] slot
);
    logic [SLOT_W-1:0] slot_q, slot_d;
    always_comb begin
        slot_d = clr ? '0 :
                 load1 ? SLOT_W'(1) :
                 inc ? ((int'(slot_q) == CH - 1) ? '0 : slot_q + SLOT_W'(1)) :
                 slot_q;
    end
    always_ff @(posedge clk) begin
        if (rst) slot_q <= '0;
        else     slot_q <= slot_d;
    end
    assign slot = slot_q;
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: collects one word per TDM slot and presents whole frames on all channels at once.
// Optional TDM_DEMUX_PARITY_EN adds even-parity checking on each incoming word.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int CH = 4,
    parameter int W  = 8
) (
    input  logic                  clk_311,
    input  logic                  rst_311,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic                  din_par_311,
    output logic                  par_err_311,
`endif
    input  logic [W-1:0]          din_311,
    input  logic                  din_valid_311,
    input  logic                  frame_start_311,
    output logic [CH*W-1:0]       dout_311,
    output logic                  dout_valid_311,
    output logic [slot_w(CH)-1:0] slot_311,
    output logic                  frame_err_311
);
    localparam int SLOT_W = slot_w(CH);
    state_e          state_q, state_d;
    logic [CH*W-1:0] shadow_q, shadow_d, dout_q, dout_d;
    logic            dv_q, dv_d, err_q, err_d, par_err_q, par_err_d;
    logic            par_bad, clr, load1, inc;
    logic [SLOT_W-1:0] slot;

    tdm_slot_counter #(.CH(CH), .SLOT_W(SLOT_W)) u_cnt (
        .clk(clk_311), .rst(rst_311), .clr(clr), .load1(load1), .inc(inc), .slot(slot)
    );

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        dout_d    = dout_q;
        dv_d      = 1'b0;
        err_d     = err_q;
        par_err_d = par_err_q;
        clr       = 1'b0;
        load1     = 1'b0;
        inc       = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        par_bad   = ^{din_311, din_par_311};
`else
        par_bad   = 1'b0;
`endif
        if (din_valid_311) begin
            if (par_bad) begin
                par_err_d = 1'b1;
                state_d   = IDLE;
                clr       = 1'b1;
            end else if (frame_start_311) begin
                // In COLLECT the slot is never 0, so any start here is early
                err_d = err_q | (state_q == COLLECT);
                shadow_d[FS_SLOT*W +: W] = din_311;
                load1   = 1'b1;
                state_d = COLLECT;
            end else if (state_q == IDLE) begin
                err_d = 1'b1;
            end else begin
                shadow_d[int'(slot)*W +: W] = din_311;
                inc = 1'b1;
                if (int'(slot) == CH - 1) begin
                    dout_d  = shadow_d;
                    dv_d    = 1'b1;
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk_311) begin
        if (rst_311) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            dout_q    <= '0;
            dv_q      <= 1'b0;
            err_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            dout_q    <= dout_d;
            dv_q      <= dv_d;
            err_q     <= err_d;
            par_err_q <= par_err_d;
        end
    end

    assign dout_311       = dout_q;
    assign dout_valid_311 = dv_q;
    assign slot_311       = slot;
    assign frame_err_311  = err_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign par_err_311    = par_err_q;
`endif
endmodule
